imem_loader: RTL and testbench

Writer side of the 1024-byte instruction memory that the fetch stage reads. It accepts a framed byte stream over a valid/ready handshake, range-checks the frame, writes the payload bytes into instruction memory, and verifies an XOR checksum. It holds the CPU (cpu_hold_o) for the whole load and reports done/error status.

---
 rtl/imem_loader_pkg.sv | 35 +++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: error codes, FSM states,
// memory size shared with the fetch-side memory, and the frame range check.
package imem_loader_pkg;

    localparam int unsigned IMEM_SIZE = 1024;

    typedef enum logic [1:0] {
        ELD_NONE  = 2'd0,
        ELD_RANGE = 2'd1,
        ELD_CSUM  = 2'd2,
        ELD_TMO   = 2'd3
    } eld_code_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LEN0  = 4'd1,
        ST_LEN1  = 4'd2,
        ST_BASE0 = 4'd3,
        ST_BASE1 = 4'd4,
        ST_DATA  = 4'd5,
        ST_CSUM  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } ld_state_e;

    // 17-bit sum so a base near the top plus a large length cannot wrap.
    function automatic logic range_ok(input logic [15:0] base,
                                      input logic [15:0] len,
                                      input int unsigned mem_size);
        logic [16:0] sum;
        sum = {1'b0, base} + {1'b0, len};
        return (len != 16'd0) && (sum <= 17'(mem_size));
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader control/stream/memory-write bundle; slave = loader, master = host side.
interface imem_loader_if;
    logic        start_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        mem_we_o;
    logic [63:0] mem_waddr_o;
    logic [7:0]  mem_wdata_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic [1:0]  err_o;

    modport slave (
        input  start_i, in_valid_i, in_data_i,
        output in_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
               cpu_hold_o, done_o, err_o
    );

    modport master (
        output start_i, in_valid_i, in_data_i,
        input  in_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
               cpu_hold_o, done_o, err_o
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream writer into instruction memory with range and XOR checks; holds the CPU during load.
// Latency: memory write registered 1 cycle after each DATA handshake; status 1 cycle after CSUM/range decision.
// Backpressure: in_ready_o high only in header/DATA/CSUM states; one byte/cycle sustained. Option: IMEM_LOADER_TIMEOUT_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE    = IMEM_SIZE
`ifdef IMEM_LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    imem_loader_if.slave  ld
);

    ld_state_e   state_q, state_d;
    eld_code_e   pend_q, pend_d;
    logic [15:0] len_q, base_q, cnt_q, waddr_q;
    logic [7:0]  csum_q, wdata_q;
    logic        mem_we_q, hold_q, done_q;
    eld_code_e   err_q;
    logic        in_ready, xfer;

    assign in_ready = state_q inside {ST_LEN0, ST_LEN1, ST_BASE0, ST_BASE1, ST_DATA, ST_CSUM};
    assign xfer     = ld.in_valid_i & in_ready;

`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [15:0] idle_q;
    logic        tmo_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                          idle_q <= 16'd0;
        else if (state_q == ST_IDLE || xfer)   idle_q <= 16'd0;
        else                                   idle_q <= idle_q + 16'd1;
    end

    // Fires on the stalled cycle that brings the idle count up to TIMEOUT_CYC.
    assign tmo_hit = in_ready && !xfer && (({16'd0, idle_q} + 32'd1) == TIMEOUT_CYC);
`endif

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE:  if (ld.start_i) state_d = ST_LEN0;
            ST_LEN0:  if (xfer) state_d = ST_LEN1;
            ST_LEN1:  if (xfer) state_d = ST_BASE0;
            ST_BASE0: if (xfer) state_d = ST_BASE1;
            ST_BASE1: if (xfer) begin
                if (range_ok({ld.in_data_i, base_q[7:0]}, len_q, MEM_SIZE)) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ERR;
                    pend_d  = ELD_RANGE;
                end
            end
            ST_DATA:  if (xfer && cnt_q == len_q - 16'd1) state_d = ST_CSUM;
            ST_CSUM:  if (xfer) begin
                if (ld.in_data_i == csum_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ERR;
                    pend_d  = ELD_CSUM;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = ST_ERR;
            pend_d  = ELD_TMO;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            pend_q   <= ELD_NONE;
            len_q    <= 16'd0;
            base_q   <= 16'd0;
            cnt_q    <= 16'd0;
            csum_q   <= 8'd0;
            waddr_q  <= 16'd0;
            wdata_q  <= 8'd0;
            mem_we_q <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ELD_NONE;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (ld.start_i) begin
                    done_q <= 1'b0;
                    err_q  <= ELD_NONE;
                    pend_q <= ELD_NONE;
                    hold_q <= 1'b1;
                    cnt_q  <= 16'd0;
                    csum_q <= 8'd0;
                end
                ST_LEN0:  if (xfer) len_q[7:0]   <= ld.in_data_i;
                ST_LEN1:  if (xfer) len_q[15:8]  <= ld.in_data_i;
                ST_BASE0: if (xfer) base_q[7:0]  <= ld.in_data_i;
                ST_BASE1: if (xfer) base_q[15:8] <= ld.in_data_i;
                ST_DATA:  if (xfer) begin
                    mem_we_q <= 1'b1;
                    waddr_q  <= base_q + cnt_q;
                    wdata_q  <= ld.in_data_i;
                    csum_q   <= csum_q ^ ld.in_data_i;
                    cnt_q    <= cnt_q + 16'd1;
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    hold_q <= 1'b0;
                end
                ST_ERR: begin
                    err_q  <= pend_q;
                    hold_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ld.in_ready_o  = in_ready;
    assign ld.mem_we_o    = mem_we_q;
    assign ld.mem_waddr_o = {48'd0, waddr_q};
    assign ld.mem_wdata_o = wdata_q;
    assign ld.cpu_hold_o  = hold_q;
    assign ld.done_o      = done_q;
    assign ld.err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame bench for imem_loader: expected writes are queued per frame, a monitor checks each write pulse.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if lif();

`ifdef IMEM_LOADER_TIMEOUT_EN
    imem_loader #(.MEM_SIZE(1024), .TIMEOUT_CYC(16)) dut (.clk_i(clk), .rst_n_i(rst_n), .ld(lif.slave));
`else
    imem_loader #(.MEM_SIZE(1024)) dut (.clk_i(clk), .rst_n_i(rst_n), .ld(lif.slave));
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  dq[$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation.
    wr_t e;
    always @(posedge clk) begin
        #1;
        if (rst_n && lif.mem_we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required no write",
                         lif.mem_waddr_o, lif.mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", lif.mem_waddr_o, {48'd0, e.addr});
                chk("wr_data", lif.mem_wdata_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int maxgap);
        repeat ($urandom_range(0, maxgap)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit st);
        int n;
        bit ok;
        lif.in_valid_i = 1'b1;
        lif.in_data_i  = b;
        lif.start_i    = st;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = lif.in_ready_o;
            tick();
            n++;
        end
        lif.in_valid_i = 1'b0;
        lif.start_i    = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout actual=no handshake required=handshake byte=%0h", b);
        end
    endtask

    task automatic do_start();
        lif.start_i = 1'b1;
        tick();
        lif.start_i = 1'b0;
        chk("hold_after_start", lif.cpu_hold_o, 1);
        chk("done_cleared", lif.done_o, 0);
        chk("err_cleared", lif.err_o, 0);
    endtask

    task automatic wait_status(input bit exp_done, input int exp_err);
        int n;
        n = 0;
        while (lif.cpu_hold_o && n < 30) begin
            tick();
            n++;
        end
        chk("hold_released", lif.cpu_hold_o, 0);
        chk("done", lif.done_o, exp_done);
        chk("err", lif.err_o, exp_err);
        chk("ready_after", lif.in_ready_o, 0);
        chk("writes_pending", exp_q.size(), 0);
    endtask

    task automatic send_header(input logic [15:0] n, input logic [15:0] b, input int maxgap);
        send_byte(n[7:0], 1'b0);  gap(maxgap);
        send_byte(n[15:8], 1'b0); gap(maxgap);
        send_byte(b[7:0], 1'b0);  gap(maxgap);
        send_byte(b[15:8], 1'b0);
    endtask

    // Reference: a frame is legal when 0 < N and B+N fits; each data byte lands at B+i; csum is XOR of data.
    task automatic run_frame(input logic [15:0] n, input logic [15:0] b, input logic [7:0] csum,
                             input int maxgap, input bit poke_start);
        logic [7:0] x;
        do_start();
        gap(maxgap);
        send_header(n, b, maxgap);
        if (n == 0 || int'(b) + int'(n) > 1024) begin
            wait_status(1'b0, 1);
        end else begin
            x = 8'h00;
            for (int i = 0; i < int'(n); i++) begin
                gap(maxgap);
                exp_q.push_back('{addr: b + 16'(i), data: dq[i]});
                x = x ^ dq[i];
                send_byte(dq[i], poke_start && i == 0);
            end
            gap(maxgap);
            send_byte(csum, 1'b0);
            if (csum == x) wait_status(1'b1, 0);
            else           wait_status(1'b0, 2);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"},  lif.cpu_hold_o, 0);
        chk({tag, "_done"},  lif.done_o, 0);
        chk({tag, "_err"},   lif.err_o, 0);
        chk({tag, "_we"},    lif.mem_we_o, 0);
        chk({tag, "_ready"}, lif.in_ready_o, 0);
        chk({tag, "_waddr"}, lif.mem_waddr_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] n, b;
        logic [7:0]  x;
        lif.start_i    = 1'b0;
        lif.in_valid_i = 1'b0;
        lif.in_data_i  = 8'h00;
        #12;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Basic load.
        dq = '{8'h30, 8'hF2, 8'h0A};
        run_frame(16'd3, 16'h0010, 8'hC8, 0, 1'b0);
        // Range overflow, then zero length.
        run_frame(16'd4, 16'h03FE, 8'h00, 0, 1'b0);
        run_frame(16'd0, 16'h0010, 8'h00, 0, 1'b0);
        // Exact top-of-memory boundary.
        dq = '{8'h11, 8'h22};
        run_frame(16'd2, 16'h03FE, 8'h33, 0, 1'b0);
        // Bad checksum.
        run_frame(16'd2, 16'h0040, 8'h00, 0, 1'b0);

        // Randomised frames, with gaps and stray start pulses while busy.
        for (int f = 0; f < 12; f++) begin
            n = 16'($urandom_range(1, 12));
            if ($urandom_range(0, 4) == 0) b = 16'($urandom_range(1025 - int'(n), 1100));
            else                           b = 16'($urandom_range(0, 1024 - int'(n)));
            dq.delete();
            x = 8'h00;
            for (int i = 0; i < int'(n); i++) begin
                dq.push_back(8'($urandom));
                x = x ^ dq[i];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            run_frame(n, b, x, 3, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of DATA.
        do_start();
        send_header(16'd6, 16'h0200, 2);
        for (int i = 0; i < 3; i++) begin
            x = 8'($urandom);
            gap(2);
            exp_q.push_back('{addr: 16'h0200 + 16'(i), data: x});
            send_byte(x, 1'b0);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        chk("midreset_writes_pending", exp_q.size(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        dq = '{8'h5A, 8'hA5, 8'h01, 8'h80};
        run_frame(16'd4, 16'h0300, 8'h5A ^ 8'hA5 ^ 8'h01 ^ 8'h80, 1, 1'b0);

        // Long stall inside DATA.
        do_start();
        send_header(16'd3, 16'h0100, 0);
        exp_q.push_back('{addr: 16'h0100, data: 8'hAA});
        send_byte(8'hAA, 1'b0);
        repeat (20) tick();
`ifdef IMEM_LOADER_TIMEOUT_EN
        wait_status(1'b0, 3);
`else
        chk("stall_hold", lif.cpu_hold_o, 1);
        chk("stall_ready", lif.in_ready_o, 1);
        exp_q.push_back('{addr: 16'h0101, data: 8'hBB});
        send_byte(8'hBB, 1'b0);
        exp_q.push_back('{addr: 16'h0102, data: 8'hCC});
        send_byte(8'hCC, 1'b0);
        send_byte(8'hAA ^ 8'hBB ^ 8'hCC, 1'b0);
        wait_status(1'b1, 0);
`endif

        repeat (3) tick();
        chk("final_writes_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
